// File: rtl/par8_bus_if.sv
// Slave end of the 8-bit host parallel bus: resynchronises the pins, locks on the two-word preamble,
// then turns host writes into an rx byte stream and serves host reads from a tx byte source.
// Optional bus_clk deglitch filter: define PAR8_GLITCH_FILTER_EN.
module par8_bus_if #(
  parameter logic [7:0]  SYNC_WORD0    = 8'hB8,
`ifdef PAR8_GLITCH_FILTER_EN
  parameter int unsigned GLITCH_CYCLES = 2,
`endif
  parameter logic [7:0]  SYNC_WORD1    = 8'h8B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_clk,
  input  logic       bus_rnw,
  input  logic [7:0] bus_data_in,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       resync,
  output logic       synced,
  output logic       overrun,
  output logic       underrun
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_GOT_W0 = 2'd1,
    ST_SYNCED = 2'd2
  } state_t;

  state_t     state_q, state_d;

  logic       bclk_s1_q, bclk_s2_q, bclk_prev_q;
  logic       rnw_s1_q, rnw_s2_q;
  logic [7:0] dat_s1_q, dat_s2_q;
  logic       bclk_lvl, bclk_rise, bclk_fall;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       tx_ready_q, tx_ready_d;
  logic       synced_q, synced_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic       wr_stb, rd_stb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      rnw_s1_q    <= 1'b0;
      rnw_s2_q    <= 1'b0;
      dat_s1_q    <= 8'h00;
      dat_s2_q    <= 8'h00;
    end else begin
      bclk_s1_q   <= bus_clk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_prev_q <= bclk_lvl;
      rnw_s1_q    <= bus_rnw;
      rnw_s2_q    <= rnw_s1_q;
      dat_s1_q    <= bus_data_in;
      dat_s2_q    <= dat_s1_q;
    end
  end

`ifdef PAR8_GLITCH_FILTER_EN
  // The filtered level follows the synced pin only after GLITCH_CYCLES consecutive differing samples.
  localparam int unsigned CW = $clog2(GLITCH_CYCLES + 1);

  logic [CW-1:0] gcnt_q, gcnt_d;
  logic          filt_q, filt_d;

  always_comb begin
    gcnt_d = '0;
    filt_d = filt_q;
    if (bclk_s2_q != filt_q) begin
      if (gcnt_q == CW'(GLITCH_CYCLES - 1)) begin
        filt_d = bclk_s2_q;
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      filt_q <= filt_d;
    end
  end

  assign bclk_lvl = filt_q;
`else
  assign bclk_lvl = bclk_s2_q;
`endif

  assign bclk_rise = bclk_lvl & ~bclk_prev_q;
  assign bclk_fall = ~bclk_lvl & bclk_prev_q;

  // Preamble hunt runs on the strobe level, not its edges; once locked only resync unlocks.
  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = ST_HUNT;
    end else if (bclk_lvl && !rnw_s2_q) begin
      unique case (state_q)
        ST_HUNT: begin
          if (dat_s2_q == SYNC_WORD0) state_d = ST_GOT_W0;
        end
        ST_GOT_W0: begin
          if (dat_s2_q == SYNC_WORD1)      state_d = ST_SYNCED;
          else if (dat_s2_q == SYNC_WORD0) state_d = ST_GOT_W0;
          else                             state_d = ST_HUNT;
        end
        ST_SYNCED: state_d = ST_SYNCED;
        default:   state_d = ST_HUNT;
      endcase
    end
  end

  assign wr_stb = (state_q == ST_SYNCED) && !rnw_s2_q && bclk_rise && !resync;
  assign rd_stb = (state_q == ST_SYNCED) &&  rnw_s2_q && bclk_fall && !resync;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    dout_d     = dout_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    tx_ready_d = 1'b0;
    if (resync) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (rx_ready) rx_valid_d = 1'b0;
      if (wr_stb) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = dat_s2_q;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d  = 1'b1;
        end
      end
      if (rd_stb) begin
        if (tx_valid) begin
          dout_d     = tx_data;
          tx_ready_d = 1'b1;
        end else begin
          dout_d     = 8'h00;
          underrun_d = 1'b1;
        end
      end
    end
    synced_d = (state_d == ST_SYNCED);
    oe_d     = synced_d && rnw_s2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HUNT;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      dout_q     <= 8'h00;
      oe_q       <= 1'b0;
      tx_ready_q <= 1'b0;
      synced_q   <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      tx_ready_q <= tx_ready_d;
      synced_q   <= synced_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus_data_out = dout_q;
  assign bus_data_oe  = oe_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_ready     = tx_ready_q;
  assign synced       = synced_q;
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_par8_bus_if.sv
// Bench for par8_bus_if: directed host bus transactions, a per-cycle reference model and literal checks.
module tb_par8_bus_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bus_clk, bus_rnw;
  logic [7:0] bus_data_in;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       resync, synced, overrun, underrun;

  int checks   = 0;
  int failures = 0;
  int n_xfer   = 0;
  int n_txr    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  par8_bus_if dut (
    .clk(clk), .reset(rst_n),
    .bus_clk(bus_clk), .bus_rnw(bus_rnw), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .resync(resync), .synced(synced), .overrun(overrun), .underrun(underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pins seen by the logic lag the pads by two clocks; outputs follow the bus rules.
  typedef struct packed { logic c; logic r; logic [7:0] d; } pins_t;
  pins_t      hist[$];
  int         m_state;  // 0 hunting, 1 first word seen, 2 locked
  logic [7:0] m_rxd, m_dout;
  logic       m_rxv, m_ovr, m_und, m_txr, m_oe, m_syn, m_filt, m_prev;

  always @(posedge clk or negedge rst_n) begin
    logic lvl, prv, rise, fall, rnw_s, lock_now;
    logic [7:0] dat_s;
    if (!rst_n) begin
      hist.delete();
      repeat (4) hist.push_front('0);
      m_state = 0; m_rxd = 8'h00; m_dout = 8'h00;
      m_rxv = 0; m_ovr = 0; m_und = 0; m_txr = 0; m_oe = 0; m_syn = 0; m_filt = 0; m_prev = 0;
    end else begin
      hist.push_front(pins_t'{bus_clk, bus_rnw, bus_data_in});
      void'(hist.pop_back());
`ifdef PAR8_GLITCH_FILTER_EN
      lvl = m_filt; prv = m_prev; m_prev = m_filt;
      if (hist[2].c != m_filt && hist[3].c != m_filt) m_filt = hist[2].c;
`else
      lvl = hist[2].c; prv = hist[3].c;
`endif
      rnw_s = hist[2].r; dat_s = hist[2].d;
      rise = lvl && !prv; fall = !lvl && prv;
      lock_now = (m_state == 2);
      m_txr = 0;
      if (resync) begin
        m_state = 0; m_rxv = 0; m_ovr = 0; m_und = 0;
      end else begin
        if (!lock_now && lvl && !rnw_s) begin
          if (dat_s == 8'h8B && m_state == 1) m_state = 2;
          else if (dat_s == 8'hB8)            m_state = 1;
          else                                m_state = 0;
        end
        if (lock_now && !rnw_s && rise && m_rxv && !rx_ready) m_ovr = 1;
        else if (lock_now && !rnw_s && rise) begin m_rxd = dat_s; m_rxv = 1; end
        else if (rx_ready) m_rxv = 0;
        if (lock_now && rnw_s && fall) begin
          if (tx_valid) begin m_dout = tx_data; m_txr = 1; end
          else begin m_dout = 8'h00; m_und = 1; end
        end
      end
      m_syn = (m_state == 2);
      m_oe  = m_syn && rnw_s;
    end
  end

  always @(posedge clk) if (rst_n && rx_valid && rx_ready) n_xfer++;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("synced",       32'(synced),       32'(m_syn));
      check("rx_valid",     32'(rx_valid),     32'(m_rxv));
      check("rx_data",      32'(rx_data),      32'(m_rxd));
      check("overrun",      32'(overrun),      32'(m_ovr));
      check("underrun",     32'(underrun),     32'(m_und));
      check("bus_data_oe",  32'(bus_data_oe),  32'(m_oe));
      check("bus_data_out", 32'(bus_data_out), 32'(m_dout));
      check("tx_ready",     32'(tx_ready),     32'(m_txr));
      if (tx_ready) n_txr++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    bus_rnw = 1'b0; bus_data_in = b; bus_clk = 1'b0; cyc(3);
    bus_clk = 1'b1; cyc(6);
  endtask

  task automatic rd();
    bus_rnw = 1'b1; bus_clk = 1'b1; cyc(4);
    bus_clk = 1'b0; cyc(6);
    bus_clk = 1'b1; cyc(4);
  endtask

  task automatic preamble(input logic [7:0] w0, input logic [7:0] w1);
    bus_rnw = 1'b0; bus_clk = 1'b1;
    bus_data_in = w0; cyc(3);
    bus_data_in = w1; cyc(3);
    cyc(3);
  endtask

  initial begin
    rst_n = 1'b0; bus_clk = 1'b0; bus_rnw = 1'b0; bus_data_in = 8'h00;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; resync = 1'b0;
    cyc(1);
    cmp_en = 1'b1;
    cyc(2);
    check("rst_synced",   32'(synced),       32'h0);
    check("rst_rx_valid", 32'(rx_valid),     32'h0);
    check("rst_oe",       32'(bus_data_oe),  32'h0);
    check("rst_dout",     32'(bus_data_out), 32'h0);
    check("rst_flags",    32'({overrun, underrun, tx_ready}), 32'h0);
    rst_n = 1'b1; cyc(2);
    check("post_rst_synced", 32'(synced), 32'h0);

    wr(8'h05);
    check("write_before_sync_rx_valid", 32'(rx_valid), 32'h0);

    bus_data_in = 8'hB8; bus_clk = 1'b1; cyc(3);
    bus_data_in = 8'h00; cyc(3);
    bus_data_in = 8'h8B; cyc(3); cyc(3);
    check("broken_preamble_synced", 32'(synced), 32'h0);

    preamble(8'hB8, 8'h8B);
    check("preamble_synced", 32'(synced), 32'h1);
    check("model_synced",    32'(m_syn),  32'h1);

    wr(8'h05);
    check("wr05_rx_valid",   32'(rx_valid), 32'h1);
    check("wr05_rx_data",    32'(rx_data),  32'h05);
    check("model_rx_data",   32'(m_rxd),    32'h05);
    n_xfer = 0;
    rx_ready = 1'b1; cyc(3); rx_ready = 1'b0; cyc(1);
    check("single_transfer", 32'(n_xfer),   32'd1);
    check("drained_rx_valid", 32'(rx_valid), 32'h0);

    wr(8'hAA);
    wr(8'h55);
    check("overrun_rx_data", 32'(rx_data), 32'hAA);
    check("overrun_flag",    32'(overrun), 32'h1);
    resync = 1'b1; cyc(1); resync = 1'b0; cyc(1);
    check("resync_overrun",  32'(overrun),  32'h0);
    check("resync_synced",   32'(synced),   32'h0);
    check("resync_rx_valid", 32'(rx_valid), 32'h0);

    preamble(8'hB8, 8'h8B);
    check("relock_synced", 32'(synced), 32'h1);

    tx_valid = 1'b1; tx_data = 8'h3C; n_txr = 0;
    bus_rnw = 1'b1; cyc(4);
    check("read_oe", 32'(bus_data_oe), 32'h1);
    bus_clk = 1'b0; cyc(6);
    bus_clk = 1'b1; cyc(3);
    check("read_dout",   32'(bus_data_out), 32'h3C);
    check("read_tx_pop", 32'(n_txr),        32'd1);
    tx_valid = 1'b0;
    rd();
    check("underrun_dout", 32'(bus_data_out), 32'h00);
    check("underrun_flag", 32'(underrun),     32'h1);
    check("no_extra_pop",  32'(n_txr),        32'd1);
    bus_rnw = 1'b0; cyc(3);
    check("oe_release", 32'(bus_data_oe), 32'h0);

    bus_data_in = 8'h77; cyc(4);
`ifdef PAR8_GLITCH_FILTER_EN
    bus_clk = 1'b0; cyc(1); bus_clk = 1'b1; cyc(8);
    check("glitch_rx_valid", 32'(rx_valid), 32'h0);
`else
    bus_clk = 1'b0; cyc(3); bus_clk = 1'b1; cyc(6);
    check("pulse_rx_valid", 32'(rx_valid), 32'h1);
    check("pulse_rx_data",  32'(rx_data),  32'h77);
`endif
    check("underrun_sticky", 32'(underrun), 32'h1);

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_synced",   32'(synced),   32'h0);
    check("async_rst_underrun", 32'(underrun), 32'h0);
    check("async_rst_dout",     32'(bus_data_out), 32'h0);
    cmp_en = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
